// File: rtl/control_pkg.sv
// control_pkg: constants shared by the multicycle RV32I control unit.
//   state_t     - Moore FSM state codes. state_dbg exposes these codes.
//   OP_*        - major opcodes that the controller recognises.
//   alu_op_t    - request from the FSM to the ALU decoder.
//   IMM_*       - immediate extender selects.
//   ALU_*       - ALU operation codes.
//   SRC*/RES_*  - datapath mux select codes.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALU_OP_ADD  = 2'b00,
        ALU_OP_SUB  = 2'b01,
        ALU_OP_FUNC = 2'b10
    } alu_op_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's alu_op request plus instruction fields onto
// the ALU operation code.
//   alu_op      in  2  add / sub / decode from function fields
//   funct3      in  3  instr[14:12]
//   op_b5       in  1  instr[5]; 1 for R-type, 0 for I-type ALU
//   funct7b5    in  1  instr[30]
//   alu_control out 3  ALU operation
module alu_decoder
    import control_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNC: begin
                case (funct3)
                    // instr[30] is part of the immediate for addi, so only
                    // an R-type instruction may select subtract.
                    3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle RV32I core
// (lw, sw, R-type, I-type ALU, beq, jal).
//   clk, reset            clock; synchronous active-high reset
//   op, funct3, funct7b5  instruction fields from the instruction register
//   zero                  ALU zero flag, used by beq
//   pc_write, ir_write, mem_write, reg_write   write strobes
//   adr_src, result_src, alu_src_a, alu_src_b  datapath mux selects
//   imm_src               immediate extender format, decoded from op only
//   alu_control           ALU operation
//   state_dbg             current state code
module multicycle_control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic [3:0] state_dbg
);

    state_t  state_q;
    state_t  state_d;
    state_t  out_state;
    alu_op_t alu_op;
    logic    pc_write_raw;
    logic    mem_write_raw;
    logic    ir_write_raw;
    logic    reg_write_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state_dbg = state_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;  // unsupported: nop
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is held the datapath sees FETCH selects, so the first
    // cycle after release already presents a valid fetch.
    assign out_state = reset ? S_FETCH : state_q;

    always_comb begin
        pc_write_raw  = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_OP_ADD;
        case (out_state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
            end
            S_DECODE: begin
                // Branch target PC+imm parked in ALUOut for a possible beq.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src    = RES_READDATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALU_OP_FUNC;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNC;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_JAL: begin
                // OldPC+4 goes to ALUOut for rd; PC takes the target from
                // ALUOut computed in DECODE.
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALU_OP_SUB;
                pc_write_raw = zero;
            end
            default: ;  // illegal codes: everything idle
        endcase
    end

    assign pc_write  = pc_write_raw  & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign ir_write  = ir_write_raw  & ~reset;
    assign reg_write = reg_write_raw & ~reset;

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control unit for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over several cycles for lw, sw, R-type, I-type ALU, beq and jal.
- Drives all datapath mux selects and write strobes.
- Drives imm_src to the immediate extender and alu_control to the ALU through an internal ALU decoder.

Parameters:
- none; opcodes and encodings are fixed constants in the shared package.

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register and OldPC enable
- reg_write  out  1  register file write strobe
- result_src  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 data
- alu_src_b  out  2  00=rs2 data, 01=imm_ext, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J (extender encoding)
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- state_dbg  out  4  current state code, for debug

Behaviour:
- Moore FSM, 4-bit state register. Codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10.
- Reset:
  - While reset=1 the state is forced to FETCH at every edge.
  - While reset=1, pc_write, ir_write, mem_write and reg_write are forced to 0; other outputs follow FETCH values.
  - First edge after reset deasserts performs a fetch.
  - Reset mid-instruction abandons it; no strobe fires in that cycle.
- Transitions:
  - FETCH→DECODE.
  - DECODE:
    - lw/sw→MEMADR
    - R (0110011)→EXECR
    - I-ALU (0010011)→EXECI
    - jal (1101111)→JAL
    - beq (1100011)→BEQ
    - any other opcode→FETCH (executes as nop).
  - MEMADR→MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR→ALUWB.
  - EXECI→ALUWB.
  - JAL→ALUWB.
  - ALUWB→FETCH.
  - BEQ→FETCH.
  - States 11-15 (illegal)→FETCH with all strobes 0.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: ir_write=1, pc_write=1, alu_src_b=10, result_src=10, alu_op=add.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=add (branch target into ALUOut).
  - MEMADR: alu_src_a=10, alu_src_b=01, add.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=func.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=func.
  - ALUWB: reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_write=1, add.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=sub; pc_write=zero (combinational from zero input).
- Latency in cycles: lw 5; sw, R, I, jal 4; beq 3; unsupported opcode 2.
- imm_src: combinational from op, independent of state.
  - 0000011 and 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else → 00
- ALU decoder (combinational):
  - alu_op add → 000.
  - alu_op sub → 001.
  - alu_op func, by funct3:
    - 000: sub if op[5]&funct7b5, else add (addi is never sub)
    - 010 → slt
    - 110 → or
    - 111 → and
    - others → add.

Decomposition:
- Package control_pkg holds:
  - state codes
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - imm_src, alu_op (2-bit: 00 add, 01 sub, 10 func) and alu_control encodings.
- One sub-module, alu_decoder: inputs alu_op, funct3, op[5], funct7b5; output alu_control.
- The FSM and imm_src decode stay in multicycle_control.

Test Plan:
- Reset held 3 cycles, then op=0000011 → state_dbg 0 while reset; all strobes 0; then 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01.
- sw op=0100011 → states 0,1,2,5,0; mem_write=1 and adr_src=1 only in state 5; imm_src=01.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → state 6 with alu_control=001, then ALUWB reg_write=1; addi with funct7b5=1 → alu_control=000.
- beq with zero=1 in BEQ → pc_write=1; repeat with zero=0 → pc_write=0; back to FETCH after 3 cycles total; imm_src=10.
- jal op=1101111 → states 0,1,9,7,0; pc_write=1 in FETCH and JAL; imm_src=11.
- Unsupported op=0000000 → DECODE→FETCH, no reg_write/mem_write; reset asserted in MEMWRITE → next state FETCH, mem_write=0 that cycle.
